// File: rtl/calendar_pkg.sv
// calendar_pkg: shared field widths, field limits, reset values and the
// month-length / set-validation helpers used by calendar_counter.
package calendar_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;

  localparam logic [SEC_W-1:0]  SEC_LAST  = 6'd59;
  localparam logic [MIN_W-1:0]  MIN_LAST  = 6'd59;
  localparam logic [HOUR_W-1:0] HOUR_LAST = 5'd23;
  localparam logic [MON_W-1:0]  MON_LAST  = 4'd12;

  localparam logic [SEC_W-1:0]  SEC_RST  = 6'd0;
  localparam logic [MIN_W-1:0]  MIN_RST  = 6'd0;
  localparam logic [HOUR_W-1:0] HOUR_RST = 5'd0;
  localparam logic [DAY_W-1:0]  DAY_RST  = 5'd1;
  localparam logic [MON_W-1:0]  MON_RST  = 4'd1;

  // year_lsbs are the two LSBs of the absolute calendar year; a zero value
  // marks a leap year (exact for 1901..2099).
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] month,
                                                     input logic [1:0]       year_lsbs);
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
      4'd2:                    return (year_lsbs == 2'd0) ? 5'd29 : 5'd28;
      default:                 return 5'd31;
    endcase
  endfunction

  function automatic logic fields_valid(input logic [SEC_W-1:0]  sec,
                                        input logic [MIN_W-1:0]  min,
                                        input logic [HOUR_W-1:0] hour,
                                        input logic [DAY_W-1:0]  day,
                                        input logic [MON_W-1:0]  month,
                                        input logic [1:0]        year_lsbs);
    return (sec <= SEC_LAST) && (min <= MIN_LAST) && (hour <= HOUR_LAST) &&
           (month != MON_W'(0)) && (month <= MON_LAST) &&
           (day != DAY_W'(0)) && (day <= days_in_month(month, year_lsbs));
  endfunction

endpackage

// File: rtl/calendar_counter_prescaler.sv
// cal_prescaler: divides enabled clk cycles down to one advance per second.
// Ports: clk, rst (sync, active-high), en (count enable), clr (restart at 0),
// adv (high on the enabled terminal-count cycle).
module cal_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic adv
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             term;

  assign term = (cnt_q == CNT_LAST);
  assign adv  = en & term;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = term ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/calendar_counter.sv
// calendar_counter: single-clock time-of-day and calendar counter with a
// seconds prescaler, month lengths/leap years, validated set handshake,
// alarm compare and year-wrap flag.
// Ports: clk, rst (sync, active-high), en (prescaler enable);
//   set_valid/set_ready + set_* load values, set_err reject pulse;
//   alarm_en + alarm_* compare values, alarm_hit pulse;
//   second/minute/hour/day/month/year current value;
//   tick_sec (time advanced) and year_wrap (year rolled to 0) pulses.
module calendar_counter
  import calendar_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int YEAR_W    = 6,
  parameter int BASE_YEAR = 2000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              set_valid,
  output logic              set_ready,
  input  logic [SEC_W-1:0]  set_second,
  input  logic [MIN_W-1:0]  set_minute,
  input  logic [HOUR_W-1:0] set_hour,
  input  logic [DAY_W-1:0]  set_day,
  input  logic [MON_W-1:0]  set_month,
  input  logic [YEAR_W-1:0] set_year,
  output logic              set_err,
  input  logic              alarm_en,
  input  logic [HOUR_W-1:0] alarm_hour,
  input  logic [MIN_W-1:0]  alarm_minute,
  input  logic [SEC_W-1:0]  alarm_second,
  output logic              alarm_hit,
  output logic [SEC_W-1:0]  second,
  output logic [MIN_W-1:0]  minute,
  output logic [HOUR_W-1:0] hour,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  month,
  output logic [YEAR_W-1:0] year,
  output logic              tick_sec,
  output logic              year_wrap
);

  // Leap test runs on the absolute year; BASE_YEAR is a multiple of 4, so
  // this offset is normally zero.
  localparam logic [1:0]        BASE_LSB = 2'(BASE_YEAR % 4);
  localparam logic [YEAR_W-1:0] YEAR_MAX = '1;

  logic [SEC_W-1:0]  second_q, second_d;
  logic [MIN_W-1:0]  minute_q, minute_d;
  logic [HOUR_W-1:0] hour_q,   hour_d;
  logic [DAY_W-1:0]  day_q,    day_d;
  logic [MON_W-1:0]  month_q,  month_d;
  logic [YEAR_W-1:0] year_q,   year_d;
  logic set_ready_q, set_err_q, alarm_hit_q, tick_q, wrap_q;

  logic [1:0] cur_yl, set_yl;
  logic xfer, set_ok, adv, do_adv, hit_d;
  logic c_sec, c_min, c_hour, c_day, c_mon, c_year;

  assign cur_yl = year_q[1:0] + BASE_LSB;
  assign set_yl = set_year[1:0] + BASE_LSB;

  assign xfer   = set_valid & set_ready_q;
  assign set_ok = xfer & fields_valid(set_second, set_minute, set_hour,
                                      set_day, set_month, set_yl);

  cal_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (set_ok),
    .adv (adv)
  );

  // Any transfer, valid or not, swallows a coincident advance.
  assign do_adv = adv & ~xfer;

  // Full carry chain evaluated in one cycle.
  assign c_sec  = (second_q == SEC_LAST);
  assign c_min  = c_sec  & (minute_q == MIN_LAST);
  assign c_hour = c_min  & (hour_q == HOUR_LAST);
  assign c_day  = c_hour & (day_q == days_in_month(month_q, cur_yl));
  assign c_mon  = c_day  & (month_q == MON_LAST);
  assign c_year = c_mon  & (year_q == YEAR_MAX);

  always_comb begin
    second_d = second_q;
    minute_d = minute_q;
    hour_d   = hour_q;
    day_d    = day_q;
    month_d  = month_q;
    year_d   = year_q;
    if (set_ok) begin
      second_d = set_second;
      minute_d = set_minute;
      hour_d   = set_hour;
      day_d    = set_day;
      month_d  = set_month;
      year_d   = set_year;
    end else if (do_adv) begin
      second_d = c_sec ? SEC_RST : second_q + SEC_W'(1);
      if (c_sec)  minute_d = c_min  ? MIN_RST  : minute_q + MIN_W'(1);
      if (c_min)  hour_d   = c_hour ? HOUR_RST : hour_q + HOUR_W'(1);
      if (c_hour) day_d    = c_day  ? DAY_RST  : day_q + DAY_W'(1);
      if (c_day)  month_d  = c_mon  ? MON_RST  : month_q + MON_W'(1);
      if (c_mon)  year_d   = year_q + YEAR_W'(1);
    end
  end

  assign hit_d = alarm_en & (set_ok | do_adv) &
                 ({hour_d, minute_d, second_d} == {alarm_hour, alarm_minute, alarm_second});

  always_ff @(posedge clk) begin
    if (rst) begin
      second_q    <= SEC_RST;
      minute_q    <= MIN_RST;
      hour_q      <= HOUR_RST;
      day_q       <= DAY_RST;
      month_q     <= MON_RST;
      year_q      <= '0;
      set_ready_q <= 1'b1;
      set_err_q   <= 1'b0;
      alarm_hit_q <= 1'b0;
      tick_q      <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      second_q    <= second_d;
      minute_q    <= minute_d;
      hour_q      <= hour_d;
      day_q       <= day_d;
      month_q     <= month_d;
      year_q      <= year_d;
      set_ready_q <= ~xfer;
      set_err_q   <= xfer & ~set_ok;
      alarm_hit_q <= hit_d;
      tick_q      <= do_adv;
      wrap_q      <= do_adv & c_year;
    end
  end

  assign set_ready = set_ready_q;
  assign set_err   = set_err_q;
  assign alarm_hit = alarm_hit_q;
  assign tick_sec  = tick_q;
  assign year_wrap = wrap_q;
  assign second    = second_q;
  assign minute    = minute_q;
  assign hour      = hour_q;
  assign day       = day_q;
  assign month     = month_q;
  assign year      = year_q;

endmodule

// File: doc/calendar_counter.md
# calendar_counter

Synchronous, parametrised time-of-day and calendar counter. It replaces the rippled per-field counter chain with a single-clock carry network and adds the following:
- a seconds prescaler
- real month lengths and leap years
- a validated set handshake
- an alarm compare and a year-wrap flag

It sits between the system clock domain and any display or monitor logic that needs wall-clock time.

## Interface
- TICK_DIV, default 1: clk cycles (with en=1) per second; must be ≥1.
- YEAR_W, default 6: width of the year offset field.
- BASE_YEAR, default 2000: calendar year for year offset 0; must be a multiple of 4.

- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  prescaler count enable
- set_valid  in  1  set request
- set_ready  out  1  block can accept a set request
- set_second, set_minute  in  6  load values
- set_hour  in  5  load value
- set_day  in  5  load value
- set_month  in  4  load value
- set_year  in  YEAR_W  load value
- set_err  out  1  one-cycle pulse: set request rejected
- alarm_en  in  1  alarm compare enable
- alarm_hour  in  5  alarm compare value
- alarm_minute, alarm_second  in  6  alarm compare values
- alarm_hit  out  1  one-cycle alarm pulse
- second, minute  out  6  current time
- hour  out  5  current time
- day  out  5  current date, 1-based
- month  out  4  current date, 1-based
- year  out  YEAR_W  current year offset
- tick_sec  out  1  one-cycle pulse: time advanced
- year_wrap  out  1  one-cycle pulse: year wrapped to 0

## Operation
- **Field ranges**
  - second and minute: 0..59; hour: 0..23.
  - month: 1..12; day: 1..days_in_month(month, year).
  - Month lengths: 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11.
  - February: 29 if year[1:0]==0, else 28. This rule is exact for years 1901–2099.
- **Prescaler**
  - Counts 0..TICK_DIV-1 on cycles with en=1 and holds when en=0.
  - At terminal count with en=1 it issues an advance and reloads 0.
- **Advance (one cycle, full carry)**
  - second increments.
  - At 59, second goes to 0 and minute increments; minute→hour and hour→day carry the same way.
  - When day equals the month length, day goes to 1 and month increments.
  - After month 12, month goes to 1 and year increments.
  - At year 2^YEAR_W−1, year goes to 0 and year_wrap is asserted.
- **Set handshake**
  - A transfer occurs when set_valid=1 and set_ready=1.
  - Validity check, all fields: second<60, minute<60, hour<24, 1≤month≤12, 1≤day≤days_in_month(set_month, set_year).
  - Valid set: all fields load; prescaler clears to 0.
  - Invalid set: no field changes and set_err is asserted.
  - set_ready is 0 in the cycle after any transfer (valid or invalid), otherwise 1.
- **Simultaneous events**
  - A set transfer coinciding with an advance: the set wins and the advance is dropped. tick_sec, alarm_hit and year_wrap are not asserted in that case.
- **Alarm**
  - alarm_hit is asserted when a time update makes hour:minute:second equal the alarm fields while alarm_en=1.
  - A time update is an advance or a valid set.
  - alarm_hit fires on entry only and is not held while the time stays equal.
- **Reset**
  - rst=1 at any edge, including mid-set or mid-count, forces:
    - 00:00:00, day 1, month 1, year 0
    - prescaler 0
    - set_ready 1
    - tick_sec, set_err, alarm_hit, year_wrap all 0
  - A set_valid presented during rst is ignored.

## Timing
- All outputs are registered and update on the clk edge.
- The first advance after reset release occurs on the TICK_DIV-th en=1 cycle, counted inclusively from the first.
- tick_sec, year_wrap and alarm_hit are high in the cycle the new field values are visible, for exactly 1 cycle.
- With TICK_DIV=1 and en held high, time advances every cycle.
- Set latency: fields show the loaded values in the cycle after the transfer edge; set_err is likewise visible one cycle after the transfer.
- After a valid set with en held high, the next advance occurs TICK_DIV cycles after the load.

## Structure
- **Package calendar_pkg**
  - Field width constants: SEC_W=6, MIN_W=6, HOUR_W=5, DAY_W=5, MON_W=4.
  - Reset field values.
  - Function days_in_month(month, year_lsbs).
  - Function fields_valid(...).
- **Sub-module cal_prescaler**
  - Parameter TICK_DIV; ports clk, rst, en, clr.
  - Output: adv pulse.
- **Top level**
  - The carry network and set/alarm logic stay in the top level; there are no per-field counter instances.

## Test plan
- **Prescaler:** TICK_DIV=4, rst then en=1 → second=1 and tick_sec=1 in the 4th cycle after rst release. Drop en for 3 cycles → count holds, no tick.
- **Month end:** set 2001-02-28 23:59:59 (year=1), then advance → 2001-03-01 00:00:00. Set year=4 (leap), Feb 28 23:59:59, then advance → Feb 29.
- **Invalid set:** set day=31, month=4 → set_err=1 for 1 cycle, fields unchanged, set_ready=0 for the following cycle. set_month=0 → rejected the same way.
- **Year wrap:** YEAR_W=6, set year=63 Dec 31 23:59:59, then advance → year=0, Jan 1 00:00:00, year_wrap=1 for 1 cycle.
- **Alarm:** alarm_en=1, alarm 12:00:00; set 11:59:59, then advance → alarm_hit once. Set 12:00:00 directly → alarm_hit once. en=0 holding the matching time → no repeat.
- **Collision and reset:** set_valid on the same edge as an advance → loaded values exactly, no tick_sec. Assert rst mid-count → all reset values on the next cycle.
